bcd_stopwatch_ctrl: RTL

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

---
 rtl/bcd_stopwatch_ctrl_pkg.sv | 17 +
 rtl/bcd_stopwatch_ctrl_if.sv | 27 ++
 rtl/bcd_stopwatch_ctrl_digit_cell.sv | 25 ++
 rtl/bcd_stopwatch_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX        = 4'd9;
  localparam int         NUM_DIGITS       = 4;
  localparam int         TICK_DIV_DEFAULT = 100000;
  // Wide enough for a prescaler terminal value of 2^20 - 1.
  localparam int         PRESC_W          = 21;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control pulses in, display/status out, plus the FSM state for observation.
interface bcd_stopwatch_ctrl_if;
  import bcd_stopwatch_ctrl_pkg::*;

  // start_stop, clear and lap are single-cycle pulses sampled on the rising
  // clock edge; there is no back-pressure, every pulse is acted on at once.
  logic                      start_stop;
  logic                      clear;
  logic                      lap;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic                      running;
  logic                      frozen;
  logic                      overflow;
  logic                      tick;
  state_t                    state;

  modport master (
    output start_stop, clear, lap,
    input  digits, running, frozen, overflow, tick, state
  );

  modport slave (
    input  start_stop, clear, lap,
    output digits, running, frozen, overflow, tick, state
  );

endinterface

// File: rtl/bcd_stopwatch_ctrl_digit_cell.sv
// One BCD decade: registered digit 0..9 with combinational carry-out.
module bcd_digit_cell
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == DIGIT_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

  assign carry = inc && (digit == DIGIT_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: prescaler, run/pause/full FSM, lap freeze.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  bcd_stopwatch_ctrl_if.slave sw
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t                  state;
  state_t                  next_state;
  logic [PRESC_W-1:0]      presc;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] lap_reg;
  logic                    frozen;
  logic                    tick;
  logic                    inc_evt;
  logic                    all_nines;
  logic                    full_hit;
  logic                    top_carry;
  logic [NUM_DIGITS-1:0]   chain;

  // Clear wins over a coincident increment, so it also suppresses Tick.
  assign inc_evt   = (state == ST_RUN) && (presc == PRESC_LAST) && !sw.clear;
  assign all_nines = (count == {NUM_DIGITS{DIGIT_MAX}});
  assign full_hit  = inc_evt && all_nines;
  assign chain[0]  = inc_evt && !all_nines;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic cout;
    bcd_digit_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .clear (sw.clear),
      .inc   (chain[i]),
      .digit (count[4*i +: 4]),
      .carry (cout)
    );
    if (i < NUM_DIGITS - 1) begin : g_link
      assign chain[i+1] = cout;
    end else begin : g_top
      assign top_carry = cout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (sw.clear) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (sw.start_stop) next_state = ST_RUN;
        ST_RUN: begin
          if (full_hit)           next_state = ST_FULL;
          else if (sw.start_stop) next_state = ST_PAUSE;
        end
        ST_PAUSE: if (sw.start_stop) next_state = ST_RUN;
        ST_FULL:  next_state = ST_FULL;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (sw.clear) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= inc_evt;
  end

  // The lap register samples the pre-increment count on the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen  <= 1'b0;
      lap_reg <= '0;
    end else if (sw.clear) begin
      frozen  <= 1'b0;
      lap_reg <= '0;
    end else if (full_hit) begin
      frozen  <= 1'b0;
    end else if ((state == ST_RUN) && sw.lap) begin
      if (frozen) begin
        frozen  <= 1'b0;
      end else begin
        frozen  <= 1'b1;
        lap_reg <= count;
      end
    end
  end

  // Saturation gates the chain input, so the top digit must never carry out.
  a_no_wrap: assert property (@(posedge clk) disable iff (rst) !top_carry);

  assign sw.digits   = frozen ? lap_reg : count;
  assign sw.running  = (state == ST_RUN);
  assign sw.overflow = (state == ST_FULL);
  assign sw.frozen   = frozen;
  assign sw.tick     = tick;
  assign sw.state    = state;

endmodule
